// File: rtl/boot_load_ctrl_if.sv
// Byte-source handshake plus instruction-memory byte-write port of the boot loader.
// The controller uses the slave modport; the byte source / memory side uses master.
interface boot_load_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        boot_wr_en;
  logic [31:0] boot_wr_addr;
  logic [7:0]  boot_wr_data;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  boot_wr_en,
    input  boot_wr_addr,
    input  boot_wr_data
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output boot_wr_en,
    output boot_wr_addr,
    output boot_wr_data
  );
endinterface

// File: rtl/boot_load_ctrl.sv
// Boot loader: receives a framed image (sync, LE length, payload, checksum) one byte at a time,
// writes the payload into instruction memory and releases the core once the checksum matches.
module boot_load_ctrl #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_BYTES      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            reset,
  boot_load_ctrl_if.slave bus,
  output logic            core_reset,
  output logic            boot_done,
  output logic            boot_error
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLen   = 3'd1;
  localparam logic [2:0] StLoad  = 3'd2;
  localparam logic [2:0] StCheck = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;
  localparam logic [2:0] StError = 3'd5;

  localparam logic [7:0]  SyncByte = 8'hA5;
  localparam logic [31:0] MaxLen   = 32'(MAX_BYTES);
  localparam int unsigned TmoW     = $clog2(TIMEOUT_CYCLES + 1);
  // Value of the idle counter one cycle before it reaches TIMEOUT_CYCLES.
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [2:0]      state_q, state_d;
  logic [1:0]      len_cnt_q, len_cnt_d;
  logic [31:0]     len_q, len_d;
  logic [31:0]     index_q, index_d;
  logic [7:0]      sum_q, sum_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            wr_en_q, wr_en_d;
  logic [31:0]     wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;

  logic        rx_ready;
  logic        accept;
  logic        timer_on;
  logic        tmo_hit;
  logic [31:0] len_full;

  assign rx_ready = (state_q == StIdle) || (state_q == StLen) ||
                    (state_q == StLoad) || (state_q == StCheck);
  assign accept   = bus.rx_valid && rx_ready;
  assign timer_on = (state_q == StLen) || (state_q == StLoad) || (state_q == StCheck);
  // An accepted byte in the same cycle always beats the timeout.
  assign tmo_hit  = timer_on && !accept && (tmo_q == TmoLast);
  // Length arrives LSB first, so shift each new byte in at the top.
  assign len_full = {bus.rx_data, len_q[31:8]};

  always_comb begin
    state_d   = state_q;
    len_cnt_d = len_cnt_q;
    len_d     = len_q;
    index_d   = index_q;
    sum_d     = sum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      StIdle: begin
        if (accept && (bus.rx_data == SyncByte)) begin
          state_d   = StLen;
          len_cnt_d = 2'd0;
          len_d     = 32'd0;
        end
      end
      StLen: begin
        if (accept) begin
          len_d     = len_full;
          len_cnt_d = len_cnt_q + 2'd1;
          if (len_cnt_q == 2'd3) begin
            if ((len_full == 32'd0) || (len_full > MaxLen)) begin
              state_d = StError;
            end else begin
              state_d = StLoad;
              index_d = 32'd0;
              sum_d   = 8'd0;
            end
          end
        end
      end
      StLoad: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = BASE_ADDR + index_q;
          wr_data_d = bus.rx_data;
          index_d   = index_q + 32'd1;
          sum_d     = sum_q + bus.rx_data;
          if (index_q == (len_q - 32'd1)) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (accept) begin
          state_d = (bus.rx_data == sum_q) ? StDone : StError;
        end
      end
      StDone, StError: begin
        state_d = state_q;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (tmo_hit) begin
      state_d = StError;
    end
  end

  // Counter is held at zero outside the framed states, which also clears it on entry to LEN.
  always_comb begin
    if (!timer_on || accept) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      len_cnt_q <= 2'd0;
      len_q     <= 32'd0;
      index_q   <= 32'd0;
      sum_q     <= 8'd0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      len_cnt_q <= len_cnt_d;
      len_q     <= len_d;
      index_q   <= index_d;
      sum_q     <= sum_d;
      tmo_q     <= tmo_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.rx_ready     = rx_ready;
  assign bus.boot_wr_en   = wr_en_q;
  assign bus.boot_wr_addr = wr_addr_q;
  assign bus.boot_wr_data = wr_data_q;

  assign core_reset = (state_q != StDone);
  assign boot_done  = (state_q == StDone);
  assign boot_error = (state_q == StError);

  done_error_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(boot_done && boot_error));
  no_write_when_stopped: assert property (@(posedge clk) disable iff (reset)
    (boot_done || boot_error) |=> !(bus.boot_wr_en && $past(boot_done || boot_error)));

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Directed and randomized frames driven into boot_load_ctrl, checked against a frame-level
// model that parses the byte stream and predicts writes and the final outcome.
module tb_boot_load_ctrl;
  localparam logic [31:0] Base     = 32'hFFFF_FFFE;
  localparam int unsigned MaxBytes = 8;
  localparam int unsigned Timeout  = 16;

  logic clk = 1'b0;
  logic reset;
  logic core_reset;
  logic boot_done;
  logic boot_error;

  boot_load_ctrl_if bus();

  boot_load_ctrl #(
    .BASE_ADDR      (Base),
    .MAX_BYTES      (MaxBytes),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .core_reset (core_reset),
    .boot_done  (boot_done),
    .boot_error (boot_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus: byte stream plus idle cycles inserted before each byte.
  logic [7:0]  stream[$];
  int          gaps[$];
  // Model results.
  bit          exp_wr[$];
  logic [31:0] exp_addr[$];
  logic [7:0]  exp_dat[$];
  int          consumed;
  int          outcome;   // 0 still running, 1 done, 2 error
  int          sync_idx;
  bit          timed_out;
  logic [31:0] last_addr;
  logic [7:0]  last_data;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(logic [7:0] b, int g);
    stream.push_back(b);
    gaps.push_back(g);
  endtask

  task automatic clear_stream();
    stream.delete();
    gaps.delete();
  endtask

  // Parse the stream as a frame: skip to the sync byte, read N, payload, checksum.
  task automatic predict();
    logic [31:0] n;
    logic [7:0]  sum;
    int          pos;
    n = 32'd0;
    sum = 8'd0;
    sync_idx = -1;
    timed_out = 1'b0;
    outcome = 0;
    consumed = stream.size();
    exp_wr.delete();
    exp_addr.delete();
    exp_dat.delete();
    for (int i = 0; i < stream.size(); i++) begin
      exp_wr.push_back(1'b0);
      exp_addr.push_back(32'd0);
      exp_dat.push_back(8'd0);
      if (sync_idx < 0) begin
        if (stream[i] == 8'hA5) sync_idx = i;
        continue;
      end
      if (gaps[i] >= Timeout) begin
        outcome = 2;
        consumed = i;
        timed_out = 1'b1;
        break;
      end
      pos = i - sync_idx - 1;
      if (pos < 4) begin
        n[8*pos +: 8] = stream[i];
        if (pos == 3 && (n == 32'd0 || n > MaxBytes)) begin
          outcome = 2;
          consumed = i + 1;
          break;
        end
      end else if (32'(pos - 4) < n) begin
        exp_wr[i] = 1'b1;
        exp_addr[i] = Base + 32'(pos - 4);
        exp_dat[i] = stream[i];
        sum = sum + stream[i];
      end else begin
        outcome = (stream[i] == sum) ? 1 : 2;
        consumed = i + 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    last_addr = Base;
    last_data = 8'd0;
  endtask

  task automatic drive_frame(string tag);
    predict();
    for (int i = 0; i < stream.size(); i++) begin
      if (i > consumed || (i == consumed && !timed_out)) break;
      for (int k = 1; k <= gaps[i]; k++) begin
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check({tag, "/idle_wr_en"}, 32'(bus.boot_wr_en), 32'd0);
        check({tag, "/idle_error"}, 32'(boot_error),
              32'(sync_idx >= 0 && i > sync_idx && k >= Timeout));
      end
      if (i == consumed) break;
      bus.rx_valid = 1'b1;
      bus.rx_data = stream[i];
      check({tag, "/rx_ready"}, 32'(bus.rx_ready), 32'd1);
      @(negedge clk);
      check({tag, "/wr_en"}, 32'(bus.boot_wr_en), 32'(exp_wr[i]));
      if (exp_wr[i]) begin
        last_addr = exp_addr[i];
        last_data = exp_dat[i];
      end
      check({tag, "/wr_addr"}, bus.boot_wr_addr, last_addr);
      check({tag, "/wr_data"}, 32'(bus.boot_wr_data), 32'(last_data));
    end
    bus.rx_valid = 1'b0;
    if (outcome != 0) begin
      // Terminal state must hold and refuse further bytes.
      for (int k = 0; k < 3; k++) begin
        bus.rx_valid = k[0];
        bus.rx_data = 8'hA5;
        check({tag, "/end_ready"}, 32'(bus.rx_ready), 32'd0);
        @(negedge clk);
        check({tag, "/end_wr_en"}, 32'(bus.boot_wr_en), 32'd0);
        check({tag, "/done"}, 32'(boot_done), 32'(outcome == 1));
        check({tag, "/error"}, 32'(boot_error), 32'(outcome == 2));
        check({tag, "/core_reset"}, 32'(core_reset), 32'(outcome != 1));
        check({tag, "/exclusive"}, 32'(boot_done & boot_error), 32'd0);
      end
      bus.rx_valid = 1'b0;
    end
  endtask

  function automatic int rand_gap();
    int r;
    r = int'($urandom_range(0, 39));
    if (r < 30) return 0;
    if (r < 37) return int'($urandom_range(1, Timeout - 1));
    return int'($urandom_range(Timeout, Timeout + 2));
  endfunction

  initial begin
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'd0;
    last_addr = Base;
    last_data = 8'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst/rx_ready", 32'(bus.rx_ready), 32'd1);
    check("rst/wr_en", 32'(bus.boot_wr_en), 32'd0);
    check("rst/wr_addr", bus.boot_wr_addr, Base);
    check("rst/wr_data", 32'(bus.boot_wr_data), 32'd0);
    check("rst/core_reset", 32'(core_reset), 32'd1);
    check("rst/done", 32'(boot_done), 32'd0);
    check("rst/error", 32'(boot_error), 32'd0);

    // Good frame, back-to-back; addresses wrap past 32'hFFFF_FFFF.
    clear_stream();
    push(8'hA5, 0); push(8'h03, 0); push(8'h00, 0); push(8'h00, 0); push(8'h00, 0);
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h66, 0);
    drive_frame("good");

    do_reset();
    clear_stream();
    push(8'hA5, 0); push(8'h03, 0); push(8'h00, 0); push(8'h00, 0); push(8'h00, 0);
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h67, 0);
    drive_frame("bad_sum");

    do_reset();
    clear_stream();
    push(8'h00, 0); push(8'hFF, 0); push(8'hA5, 0);
    push(8'h00, 0); push(8'h00, 0); push(8'h00, 0); push(8'h00, 0);
    drive_frame("len_zero");

    do_reset();
    clear_stream();
    push(8'hA5, 0); push(8'(MaxBytes + 1), 0); push(8'h00, 0); push(8'h00, 0); push(8'h00, 0);
    drive_frame("len_big");

    do_reset();
    clear_stream();
    push(8'hA5, 0); push(8'h02, 0); push(8'h00, 0); push(8'h00, 0); push(8'h00, 0);
    push(8'h11, 0); push(8'h22, 16); push(8'h33, 0);
    drive_frame("tmo16");

    do_reset();
    clear_stream();
    push(8'hA5, 0); push(8'h02, 0); push(8'h00, 0); push(8'h00, 0); push(8'h00, 0);
    push(8'h11, 0); push(8'h22, 15); push(8'h33, 0);
    drive_frame("tmo15");

    // Reset lands while a payload byte is being accepted: its write must not appear.
    do_reset();
    clear_stream();
    push(8'hA5, 0); push(8'h03, 0); push(8'h00, 0); push(8'h00, 0); push(8'h00, 0);
    push(8'h11, 0); push(8'h22, 0);
    drive_frame("rst_mid");
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h33;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.rx_valid = 1'b0;
    check("rst_mid/wr_en", 32'(bus.boot_wr_en), 32'd0);
    check("rst_mid/wr_addr", bus.boot_wr_addr, Base);
    check("rst_mid/wr_data", 32'(bus.boot_wr_data), 32'd0);
    check("rst_mid/rx_ready", 32'(bus.rx_ready), 32'd1);
    check("rst_mid/core_reset", 32'(core_reset), 32'd1);
    check("rst_mid/error", 32'(boot_error), 32'd0);
    last_addr = Base;
    last_data = 8'd0;
    clear_stream();
    push(8'hA5, 0); push(8'h03, 0); push(8'h00, 0); push(8'h00, 0); push(8'h00, 0);
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h66, 0);
    drive_frame("rst_fresh");

    for (int t = 0; t < 40; t++) begin
      logic [31:0] n;
      logic [7:0]  b;
      logic [7:0]  sum;
      int          mode;
      do_reset();
      clear_stream();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        push(b, int'($urandom_range(0, 20)));
      end
      push(8'hA5, int'($urandom_range(0, 20)));
      mode = int'($urandom_range(0, 9));
      if (mode == 0) n = 32'd0;
      else if (mode == 1) n = MaxBytes + 1;
      else if (mode == 2) n = 32'h0100_0000 | 32'($urandom_range(1, MaxBytes));
      else n = 32'($urandom_range(1, MaxBytes));
      for (int j = 0; j < 4; j++) push(n[8*j +: 8], rand_gap());
      sum = 8'd0;
      if (n >= 1 && n <= MaxBytes) begin
        for (int j = 0; j < int'(n); j++) begin
          b = 8'($urandom_range(0, 255));
          sum = sum + b;
          push(b, rand_gap());
        end
        if ($urandom_range(0, 3) == 0) sum = sum ^ 8'($urandom_range(1, 255));
        push(sum, rand_gap());
      end
      drive_frame($sformatf("rand%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
